// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle of the serial receiver.
//   rx            serial line into the receiver (idle high)
//   data/valid    received byte and its valid flag, held until accepted
//   ready         consumer accepts the byte when valid&ready at a clock edge
//   framing_error one-cycle pulse, stop bit sampled low
//   overrun       one-cycle pulse, byte completed while the previous one was pending
//   busy          receiver is inside a frame
// slave  = receiver side, master = line driver / byte consumer side.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  modport slave (
    input  rx, ready,
    output data, valid, framing_error, overrun, busy
  );

  modport master (
    output rx, ready,
    input  data, valid, framing_error, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: serial receiver, 1 start (0) + 8 data bits MSB-first + 1 stop (1).
// Ports:
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   port         uart_rx_if.slave (rx in, ready in; data/valid/framing_error/
//                overrun/busy out, all registered)
// CLKS_PER_BIT sets the bit period; 1 matches a transmitter that shifts one
// bit per clock, in which case frames may arrive back to back with no gap.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  uart_rx_if.slave port
);
  localparam int N    = CLKS_PER_BIT;
  localparam int HALF = (N - 1) / 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitidx;
  logic [7:0]      shift;
  logic            armed;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            fe_q;
  logic            ov_q;
  logic            busy_q;

  assign port.data          = data_q;
  assign port.valid         = valid_q;
  assign port.framing_error = fe_q;
  assign port.overrun       = ov_q;
  assign port.busy          = busy_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= IDLE;
      cnt     <= '0;
      bitidx  <= '0;
      shift   <= '0;
      armed   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      // Accept; a delivery in the STOP branch below overrides this.
      if (valid_q && port.ready) valid_q <= 1'b0;

      case (state)
        IDLE: begin
          // armed only rises on a high line, so a line stuck low after a
          // framing error or reset can never look like a stream of starts.
          if (port.rx) armed <= 1'b1;
          if (armed && !port.rx) begin
            busy_q <= 1'b1;
            bitidx <= '0;
            if (HALF == 0) begin
              state <= DATA;
              cnt   <= CNT_BIT;
            end else begin
              state <= START;
              cnt   <= CNT_HALF;
            end
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!port.rx) begin
            // Mid-bit confirm of the start bit; data sampling is now centred.
            state  <= DATA;
            cnt    <= CNT_BIT;
            bitidx <= '0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift <= {shift[6:0], port.rx};
            cnt   <= CNT_BIT;
            if (bitidx == 3'd7) state <= STOP;
            else                bitidx <= bitidx + 1'b1;
          end
        end

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Back to IDLE right away so a start bit in the very next cycle
            // is caught (gapless frames at one clock per bit).
            state  <= IDLE;
            busy_q <= 1'b0;
            if (port.rx) begin
              if (!valid_q || port.ready) begin
                data_q  <= shift;
                valid_q <= 1'b1;
              end else begin
                ov_q <= 1'b1;
              end
            end else begin
              fe_q  <= 1'b1;
              armed <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int MAXC = 1024;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_if if1 ();
  uart_rx_if if5 ();

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .port(if1.slave));
  uart_rx #(.CLKS_PER_BIT(5)) dut5 (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .port(if5.slave));

  int checks = 0;
  int errors = 0;

  bit   sel5;
  int   n_cur;
  int   len;
  bit   rxs [MAXC+1];
  bit   rdy [MAXC+1];

  // expected / observed outputs, index c = cycle after inputs of cycle c-1
  bit         e_v [MAXC+1], e_fe [MAXC+1], e_ov [MAXC+1], e_busy [MAXC+1];
  logic [7:0] e_d [MAXC+1];
  logic       o_v [MAXC+1], o_fe [MAXC+1], o_ov [MAXC+1], o_busy [MAXC+1];
  logic [7:0] o_d [MAXC+1];
  int         ev_kind [MAXC+1];   // 1 = good frame ends here, 2 = bad stop
  logic [7:0] ev_byte [MAXC+1];

  // ---------------- stimulus building ----------------
  task automatic new_stream(input int n);
    sel5 = (n == 5);
    n_cur = n;
    len = 0;
    for (int i = 0; i <= MAXC; i++) begin
      rxs[i] = 1'b1;
      rdy[i] = 1'b0;
    end
  endtask

  task automatic add_idle(input int cyc, input bit val);
    for (int i = 0; i < cyc; i++) begin
      if (len < MAXC - 1) begin
        rxs[len] = val;
        len++;
      end
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop);
    add_idle(n_cur, 1'b0);
    for (int k = 7; k >= 0; k--) add_idle(n_cur, b[k]);
    add_idle(n_cur, stop);
  endtask

  // ---------------- reference model ----------------
  // Frame-level: find start edges, read the line at the documented sample
  // instants, then replay the byte handshake over the ready pattern.
  function automatic void model();
    int c, t, s, h;
    bit armed, v, acc, fe, ov;
    logic [7:0] b, d;
    h = (n_cur - 1) / 2;
    for (int i = 0; i <= MAXC; i++) begin
      ev_kind[i] = 0;
      ev_byte[i] = '0;
      e_busy[i]  = 1'b0;
    end
    c = 0;
    armed = 1'b0;
    while (c < len) begin
      if (rxs[c]) begin
        armed = 1'b1;
        c++;
      end else if (!armed) begin
        c++;
      end else begin
        t = c;
        if (rxs[t+h]) begin
          for (int j = t + 1; j <= t + h; j++) e_busy[j] = 1'b1;
          c = t + h + 1;
        end else begin
          s = t + h + 9 * n_cur;
          if (s >= MAXC) break;
          b = '0;
          for (int k = 0; k < 8; k++) b = {b[6:0], rxs[t+h+(k+1)*n_cur]};
          for (int j = t + 1; j <= s; j++) e_busy[j] = 1'b1;
          if (rxs[s]) begin
            ev_kind[s] = 1;
            ev_byte[s] = b;
          end else begin
            ev_kind[s] = 2;
            armed = 1'b0;
          end
          c = s + 1;
        end
      end
    end
    v = 1'b0;
    d = '0;
    e_v[0] = 1'b0; e_d[0] = '0; e_fe[0] = 1'b0; e_ov[0] = 1'b0;
    for (int i = 0; i < len; i++) begin
      fe = 1'b0;
      ov = 1'b0;
      acc = v && rdy[i];
      if (ev_kind[i] == 1 && (!v || acc)) begin
        d = ev_byte[i];
        v = 1'b1;
      end else begin
        if (acc) v = 1'b0;
        if (ev_kind[i] == 1) ov = 1'b1;
        if (ev_kind[i] == 2) fe = 1'b1;
      end
      e_v[i+1] = v; e_d[i+1] = d; e_fe[i+1] = fe; e_ov[i+1] = ov;
    end
  endfunction

  // ---------------- drive / record ----------------
  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    if1.rx = 1'b1; if1.ready = 1'b0;
    if5.rx = 1'b1; if5.ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
  endtask

  task automatic run_stream();
    for (int c = 0; c < len; c++) begin
      if (sel5) begin
        if5.rx = rxs[c]; if5.ready = rdy[c]; if1.rx = 1'b1; if1.ready = 1'b0;
      end else begin
        if1.rx = rxs[c]; if1.ready = rdy[c]; if5.rx = 1'b1; if5.ready = 1'b0;
      end
      @(posedge CLK);
      #1;
      o_v[c+1]    = sel5 ? if5.valid         : if1.valid;
      o_d[c+1]    = sel5 ? if5.data          : if1.data;
      o_fe[c+1]   = sel5 ? if5.framing_error : if1.framing_error;
      o_ov[c+1]   = sel5 ? if5.overrun       : if1.overrun;
      o_busy[c+1] = sel5 ? if5.busy          : if1.busy;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    if1.rx = 1'b1; if1.ready = 1'b0; if5.rx = 1'b1; if5.ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({if1.data, if1.valid, if1.framing_error, if1.overrun, if1.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_n1 got %h want 000", {if1.data, if1.valid, if1.framing_error, if1.overrun, if1.busy});
    end
    checks++;
    if ({if5.data, if5.valid, if5.framing_error, if5.overrun, if5.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_n5 got %h want 000", {if5.data, if5.valid, if5.framing_error, if5.overrun, if5.busy});
    end
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_single();
    int t;
    do_reset();
    new_stream(1);
    add_idle(3, 1'b1);
    t = len;
    add_frame(8'hA5, 1'b1);
    add_idle(12, 1'b1);
    rdy[t+12] = 1'b1;
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL single cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
    checks++;
    if ({o_v[t+9], o_v[t+10], o_d[t+10], o_v[t+12], o_v[t+13]} !== {1'b0, 1'b1, 8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_timing got v9=%b v10=%b d10=%h v12=%b v13=%b want 0 1 a5 1 0",
               o_v[t+9], o_v[t+10], o_d[t+10], o_v[t+12], o_v[t+13]);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    new_stream(1);
    add_idle(3, 1'b1);
    t = len;
    add_frame(8'h3C, 1'b1);
    add_frame(8'hFF, 1'b1);
    add_idle(12, 1'b1);
    for (int i = 0; i < len; i++) rdy[i] = 1'b1;
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL b2b cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
    checks++;
    if ({o_v[t+10], o_d[t+10], o_v[t+11], o_v[t+20], o_d[t+20], o_ov[t+20], o_fe[t+20]} !==
        {1'b1, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_timing got v10=%b d10=%h v11=%b v20=%b d20=%h ov=%b fe=%b want 1 3c 0 1 ff 0 0",
               o_v[t+10], o_d[t+10], o_v[t+11], o_v[t+20], o_d[t+20], o_ov[t+20], o_fe[t+20]);
    end
  endtask

  task automatic test_overrun();
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      new_stream(1);
      add_idle(3, 1'b1);
      t = len;
      add_frame(8'h12, 1'b1);
      add_frame(8'h34, 1'b1);
      add_idle(12, 1'b1);
      // second pass: accept coincides with the second byte's stop sample
      if (pass == 1) rdy[t+19] = 1'b1;
      model();
      run_stream();
      for (int c = 1; c <= len; c++) begin
        checks++;
        if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
          errors++;
          $display("FAIL overrun%0d cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", pass, c,
                   o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
        end
      end
      checks++;
      if (pass == 0 && {o_v[t+20], o_d[t+20], o_ov[t+20], o_ov[t+21]} !== {1'b1, 8'h12, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL overrun_pulse got v=%b d=%h ov20=%b ov21=%b want 1 12 1 0",
                 o_v[t+20], o_d[t+20], o_ov[t+20], o_ov[t+21]);
      end
      if (pass == 1 && {o_v[t+20], o_d[t+20], o_ov[t+20]} !== {1'b1, 8'h34, 1'b0}) begin
        errors++;
        $display("FAIL overrun_accept got v=%b d=%h ov=%b want 1 34 0", o_v[t+20], o_d[t+20], o_ov[t+20]);
      end
    end
  endtask

  task automatic test_framing();
    int t, t2;
    bit any_busy;
    do_reset();
    new_stream(1);
    add_idle(3, 1'b1);
    t = len;
    add_frame(8'h55, 1'b0);
    add_idle(30, 1'b0);
    add_idle(1, 1'b1);
    t2 = len;
    add_frame(8'h81, 1'b1);
    add_idle(12, 1'b1);
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL framing cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
    checks++;
    if ({o_fe[t+10], o_v[t+10], o_fe[t+11]} !== 3'b100) begin
      errors++;
      $display("FAIL framing_pulse got fe10=%b v10=%b fe11=%b want 1 0 0", o_fe[t+10], o_v[t+10], o_fe[t+11]);
    end
    any_busy = 1'b0;
    for (int c = t + 10; c <= t + 40; c++) if (o_busy[c] !== 1'b0) any_busy = 1'b1;
    checks++;
    if (any_busy) begin
      errors++;
      $display("FAIL framing_low_busy got busy during held-low line want 0");
    end
    checks++;
    if ({o_v[t2+10], o_d[t2+10]} !== {1'b1, 8'h81}) begin
      errors++;
      $display("FAIL framing_recover got v=%b d=%h want 1 81", o_v[t2+10], o_d[t2+10]);
    end
  endtask

  task automatic test_n5();
    int t, g;
    do_reset();
    new_stream(5);
    add_idle(3, 1'b1);
    t = len;
    add_frame(8'hC3, 1'b1);
    add_idle(10, 1'b1);
    g = len;
    add_idle(1, 1'b0);
    add_idle(15, 1'b1);
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL n5 cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
    checks++;
    if ({o_v[t+47], o_v[t+48], o_d[t+48], o_busy[t+47], o_busy[t+48]} !== {1'b0, 1'b1, 8'hC3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL n5_timing got v47=%b v48=%b d=%h b47=%b b48=%b want 0 1 c3 1 0",
               o_v[t+47], o_v[t+48], o_d[t+48], o_busy[t+47], o_busy[t+48]);
    end
    checks++;
    if ({o_busy[g+1], o_busy[g+2], o_busy[g+3], o_fe[g+3], o_ov[g+3]} !== 5'b11000) begin
      errors++;
      $display("FAIL n5_glitch got b1=%b b2=%b b3=%b fe=%b ov=%b want 1 1 0 0 0",
               o_busy[g+1], o_busy[g+2], o_busy[g+3], o_fe[g+3], o_ov[g+3]);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    new_stream(1);
    add_idle(3, 1'b1);
    t = len;
    add_frame(8'h7E, 1'b1);
    len = t + 4;
    run_stream();
    ASYNCRESETN = 1'b0;
    if1.rx = 1'b0;
    #1;
    checks++;
    if ({if1.data, if1.valid, if1.framing_error, if1.overrun, if1.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid got %h want 000", {if1.data, if1.valid, if1.framing_error, if1.overrun, if1.busy});
    end
    @(posedge CLK);
    @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;
    new_stream(1);
    add_idle(5, 1'b0);
    add_idle(2, 1'b1);
    t = len;
    add_frame(8'h7E, 1'b1);
    add_idle(12, 1'b1);
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
    checks++;
    if ({o_busy[1], o_busy[5], o_v[t+10], o_d[t+10]} !== {1'b0, 1'b0, 1'b1, 8'h7E}) begin
      errors++;
      $display("FAIL reset_mid_recover got b1=%b b5=%b v=%b d=%h want 0 0 1 7e",
               o_busy[1], o_busy[5], o_v[t+10], o_d[t+10]);
    end
  endtask

  task automatic test_random(input int n);
    do_reset();
    new_stream(n);
    add_idle(2, 1'b1);
    while (len < MAXC - 200) begin
      add_idle($urandom_range(0, 3), 1'b1);
      add_frame(8'($urandom), ($urandom_range(0, 7) != 0));
    end
    add_idle(12 * n, 1'b1);
    for (int i = 0; i < len; i++) rdy[i] = 1'($urandom_range(0, 1));
    model();
    run_stream();
    for (int c = 1; c <= len; c++) begin
      checks++;
      if ({o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c]} !== {e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]}) begin
        errors++;
        $display("FAIL random_n%0d cyc %0d got v%b d%h fe%b ov%b b%b want v%b d%h fe%b ov%b b%b", n, c,
                 o_v[c], o_d[c], o_fe[c], o_ov[c], o_busy[c], e_v[c], e_d[c], e_fe[c], e_ov[c], e_busy[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_n5();
    test_reset_mid();
    test_random(1);
    test_random(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
